// File: rtl/obi_sram_responder.sv
// OBI responder backed by a word-organised SRAM model. Writes use byte enables.
// The grant wait is programmable, and responses return through a fixed-latency pipeline.

package obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module obi_sram_responder
   import obi_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 1024,
   parameter int unsigned GNT_WAIT  = 0,
   parameter int unsigned RESP_LAT  = 1
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  obi_req_t  obi_req_i,
   output obi_resp_t obi_resp_o
);

   localparam int unsigned IdxW    = $clog2(NUM_WORDS);
   localparam logic [31:0] OorData = 32'hBADC_AB1E;

   logic            gnt;
   logic            accept;
   logic            in_range;
   logic [IdxW-1:0] word_idx;
   logic [31:0]     resp_data;
   logic            unused_addr_lsb;

   assign word_idx        = obi_req_i.addr[IdxW+1:2];
   assign in_range        = {2'b00, obi_req_i.addr[31:2]} < NUM_WORDS;
   assign accept          = obi_req_i.req & gnt;
   assign unused_addr_lsb = ^obi_req_i.addr[1:0];

   if (GNT_WAIT == 0) begin : g_comb_gnt
      assign gnt = obi_req_i.req & ~rst_i;
   end else begin : g_wait_gnt
      localparam int unsigned     CntW   = $clog2(GNT_WAIT + 1);
      localparam logic [CntW-1:0] CntMax = CntW'(GNT_WAIT);

      typedef enum logic {StIdle, StWait} state_e;

      state_e          state;
      logic [CntW-1:0] wait_cnt;

      assign gnt = (state == StWait) & (wait_cnt == CntMax) & obi_req_i.req;

      // Grant FSM. Every grant passes back through idle, so held requests see GNT_WAIT+1 spacing.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state    <= StIdle;
            wait_cnt <= '0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (obi_req_i.req) begin
                     state    <= StWait;
                     wait_cnt <= CntW'(1);
                  end
               end
               StWait: begin
                  if (!obi_req_i.req || wait_cnt == CntMax) begin
                     // Dropped request or grant: both restart the wait from scratch
                     state    <= StIdle;
                     wait_cnt <= '0;
                  end else begin
                     // Only reached below CntMax, so the counter saturates there
                     wait_cnt <= wait_cnt + CntW'(1);
                  end
               end
            endcase
         end
      end
   end

   logic [31:0] mem [NUM_WORDS];

   // Byte-lane writes at the grant edge. Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (accept && obi_req_i.we && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (obi_req_i.be[i]) begin
               mem[word_idx][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
            end
         end
      end
   end

   // Response payload captured at the grant edge: zero for writes, sentinel for unmapped reads.
   always_comb begin
      resp_data = '0;
      if (!obi_req_i.we) begin
         resp_data = in_range ? mem[word_idx] : OorData;
      end
   end

   logic [RESP_LAT-1:0] pipe_valid;
   logic [31:0]         pipe_data [RESP_LAT];

   // Fixed-latency response shift register. Data moves only alongside a valid,
   // so the last stage holds rdata between pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         for (int i = 0; i < RESP_LAT; i++) begin
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_valid[0] <= accept;
         if (accept) begin
            pipe_data[0] <= resp_data;
         end
         for (int i = 1; i < RESP_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            if (pipe_valid[i-1]) begin
               pipe_data[i] <= pipe_data[i-1];
            end
         end
      end
   end

   // Response port assembly
   always_comb begin
      obi_resp_o.gnt    = gnt;
      obi_resp_o.rvalid = pipe_valid[RESP_LAT-1];
      obi_resp_o.rdata  = pipe_data[RESP_LAT-1];
   end

endmodule

// File: tb/tb_obi_sram_responder.sv
// Bench for obi_sram_responder. It runs three configurations side by side.
// A transaction-level model predicts gnt/rvalid/rdata on every cycle.
// Directed scenarios add hand-computed expectations.

module tb_obi_sram_responder;
   import obi_pkg::*;

   localparam int NW = 64;

   logic      clk;
   logic      rst;
   obi_req_t  rq [3];
   obi_resp_t rs [3];
   obi_resp_t rs_a, rs_b, rs_c;

   assign rs[0] = rs_a;
   assign rs[1] = rs_b;
   assign rs[2] = rs_c;

   obi_sram_responder #(.NUM_WORDS(NW), .GNT_WAIT(0), .RESP_LAT(1)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .obi_req_i(rq[0]), .obi_resp_o(rs_a)
   );
   obi_sram_responder #(.NUM_WORDS(NW), .GNT_WAIT(2), .RESP_LAT(3)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .obi_req_i(rq[1]), .obi_resp_o(rs_b)
   );
   obi_sram_responder #(.NUM_WORDS(NW), .GNT_WAIT(0), .RESP_LAT(3)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .obi_req_i(rq[2]), .obi_resp_o(rs_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Model state, per instance
   int          gw [3] = '{0, 2, 0};
   int          lt [3] = '{1, 3, 3};
   int          run [3];
   logic [31:0] mm [3][NW];
   logic [3:0]  mk [3][NW];
   bit          sv [3][8];
   logic [31:0] sd [3][8];
   bit          sk [3][8];
   logic [31:0] last_rd [3];
   bit          last_kn [3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Predict this cycle's outputs, then apply any transaction accepted at the coming edge
   task automatic model_check();
      for (int k = 0; k < 3; k++) begin
         logic        eg;
         int          sl;
         int          w;
         logic [31:0] d;
         bit          kn;
         bit          inr;
         if (rst) begin
            chk("rst_gnt", 32'(rs[k].gnt), 32'd0);
            chk("rst_rvalid", 32'(rs[k].rvalid), 32'd0);
            chk("rst_rdata", rs[k].rdata, 32'd0);
            run[k] = 0;
            for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
            last_rd[k] = 32'd0;
            last_kn[k] = 1'b1;
         end else begin
            eg = rq[k].req && (run[k] >= gw[k]);
            sl = cyc % 8;
            chk("gnt", 32'(rs[k].gnt), 32'(eg));
            chk("rvalid", 32'(rs[k].rvalid), 32'(sv[k][sl]));
            if (sv[k][sl]) begin
               last_rd[k] = sd[k][sl];
               last_kn[k] = sk[k][sl];
               sv[k][sl]  = 1'b0;
            end
            if (last_kn[k]) chk("rdata", rs[k].rdata, last_rd[k]);
            if (eg) begin
               inr = rq[k].addr[31:2] < NW;
               w   = inr ? int'(rq[k].addr[7:2]) : 0;
               if (rq[k].we) begin
                  if (inr) begin
                     for (int b = 0; b < 4; b++) begin
                        if (rq[k].be[b]) begin
                           mm[k][w][8*b +: 8] = rq[k].wdata[8*b +: 8];
                           mk[k][w][b]        = 1'b1;
                        end
                     end
                  end
                  d  = 32'd0;
                  kn = 1'b1;
               end else if (inr) begin
                  d  = mm[k][w];
                  kn = &mk[k][w];
               end else begin
                  d  = 32'hBADCAB1E;
                  kn = 1'b1;
               end
               sv[k][(cyc + lt[k]) % 8] = 1'b1;
               sd[k][(cyc + lt[k]) % 8] = d;
               sk[k][(cyc + lt[k]) % 8] = kn;
               run[k] = 0;
            end else begin
               run[k] = rq[k].req ? run[k] + 1 : 0;
            end
         end
      end
   endtask

   // One clock cycle: check at negedge, return just after the next rising edge
   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drive(input int k, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      rq[k].req   = 1'b1;
      rq[k].we    = we;
      rq[k].be    = be;
      rq[k].addr  = addr;
      rq[k].wdata = wdata;
   endtask

   // Complete one transaction on instance k with bounded waits
   task automatic xfer(input int k, input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd);
      int n;
      drive(k, we, be, addr, wdata);
      n = 0;
      #1;
      while (!rs[k].gnt && n < 20) begin
         step();
         #1;
         n++;
      end
      chk("xfer_gnt_wait", 32'(rs[k].gnt), 32'd1);
      step();
      rq[k].req = 1'b0;
      #1;
      n = 0;
      while (!rs[k].rvalid && n < 20) begin
         step();
         #1;
         n++;
      end
      chk("xfer_rvalid_wait", 32'(rs[k].rvalid), 32'd1);
      rd = rs[k].rdata;
      step();
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] pre [3];
      int          gcyc [3];
      int          rcyc [3];
      logic [31:0] rdat [3];
      int          g_idx;
      int          r_idx;
      logic [29:0] word;

      for (int k = 0; k < 3; k++) begin
         run[k]     = 0;
         last_rd[k] = 32'd0;
         last_kn[k] = 1'b1;
         for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
         for (int w = 0; w < NW; w++) mk[k][w] = 4'b0000;
      end

      // 1. Reset held with requests pending
      rst = 1'b1;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 4'hF, 32'h10, 32'd0);
      step();
      step();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t1_rst_gnt", 32'(rs[k].gnt), 32'd0);
         chk("t1_rst_rvalid", 32'(rs[k].rvalid), 32'd0);
      end
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) rq[k].req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t1_idle_rvalid", 32'(rs[1].rvalid), 32'd0);
         step();
      end

      // 2. Back-to-back write/read, zero wait, latency 1
      drive(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
      #1;
      chk("t2_wr_gnt", 32'(rs[0].gnt), 32'd1);
      step();
      drive(0, 1'b0, 4'b1111, 32'h10, 32'd0);
      #1;
      chk("t2_rd_gnt", 32'(rs[0].gnt), 32'd1);
      chk("t2_wr_rvalid", 32'(rs[0].rvalid), 32'd1);
      chk("t2_wr_rdata", rs[0].rdata, 32'd0);
      step();
      rq[0].req = 1'b0;
      #1;
      chk("t2_rd_rvalid", 32'(rs[0].rvalid), 32'd1);
      chk("t2_rd_rdata", rs[0].rdata, 32'hDEADBEEF);
      step();

      // 3. Byte enables merge into the existing word
      drive(0, 1'b1, 4'b0101, 32'h10, 32'h11223344);
      step();
      drive(0, 1'b0, 4'b1111, 32'h10, 32'd0);
      step();
      rq[0].req = 1'b0;
      #1;
      chk("t3_rd_rdata", rs[0].rdata, 32'hDE22BE44);
      step();
      #1;
      chk("t3_hold_rvalid", 32'(rs[0].rvalid), 32'd0);
      chk("t3_hold_rdata", rs[0].rdata, 32'hDE22BE44);

      // 4. Wait states and pipelining: three reads with req held continuously
      pre[0] = 32'hA0A0_0001;
      pre[1] = 32'hB1B1_0002;
      pre[2] = 32'hC2C2_0003;
      for (int i = 0; i < 3; i++) xfer(1, 1'b1, 4'hF, 32'h20 + 32'(4 * i), pre[i], rd);
      g_idx = 0;
      r_idx = 0;
      drive(1, 1'b0, 4'hF, 32'h20, 32'd0);
      for (int c = 0; c < 40 && r_idx < 3; c++) begin
         #1;
         if (rs[1].rvalid && r_idx < 3) begin
            rcyc[r_idx] = cyc;
            rdat[r_idx] = rs[1].rdata;
            r_idx++;
         end
         if (rs[1].gnt && g_idx < 3) begin
            gcyc[g_idx] = cyc;
            g_idx++;
         end
         step();
         if (g_idx < 3) rq[1].addr = 32'h20 + 32'(4 * g_idx);
         else rq[1].req = 1'b0;
      end
      chk("t4_resp_count", 32'(r_idx), 32'd3);
      if (r_idx == 3) begin
         chk("t4_gnt_gap01", 32'(gcyc[1] - gcyc[0]), 32'd3);
         chk("t4_gnt_gap12", 32'(gcyc[2] - gcyc[1]), 32'd3);
         for (int i = 0; i < 3; i++) begin
            chk("t4_lat", 32'(rcyc[i] - gcyc[i]), 32'd3);
            chk("t4_data", rdat[i], pre[i]);
         end
      end

      // 5. Out-of-range accesses do not alias onto word 0
      xfer(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd);
      xfer(0, 1'b1, 4'hF, 32'(NW * 4), 32'h12345678, rd);
      xfer(0, 1'b0, 4'hF, 32'(NW * 4), 32'd0, rd);
      chk("t5_oor_rdata", rd, 32'hBADCAB1E);
      xfer(0, 1'b0, 4'hF, 32'h0, 32'd0, rd);
      chk("t5_word0", rd, 32'hCAFEF00D);

      // 6. Reset with two reads in flight, latency 3
      xfer(2, 1'b1, 4'hF, 32'h40, 32'h600D0040, rd);
      xfer(2, 1'b1, 4'hF, 32'h44, 32'h600D0044, rd);
      drive(2, 1'b0, 4'hF, 32'h40, 32'd0);
      step();
      rq[2].addr = 32'h44;
      step();
      rq[2].req = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("t6_no_rvalid", 32'(rs[2].rvalid), 32'd0);
         step();
      end
      xfer(2, 1'b0, 4'hF, 32'h44, 32'd0, rd);
      chk("t6_after_rst", rd, 32'h600D0044);

      // Randomised traffic on all instances with occasional resets
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < 3; k++) begin
            rq[k].req = ($urandom % 10) < 7;
            rq[k].we  = 1'($urandom);
            rq[k].be  = 4'($urandom);
            case ($urandom % 10)
               0: word = 30'($urandom) | 30'h2000_0000;
               1: word = 30'(NW + $urandom_range(0, 100));
               default: word = 30'($urandom_range(0, 15));
            endcase
            rq[k].addr  = {word, 2'($urandom)};
            rq[k].wdata = $urandom;
         end
         if (rst) rst = 1'b0;
         else if ($urandom % 300 == 0) rst = 1'b1;
         step();
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) rq[k].req = 1'b0;
      for (int c = 0; c < 8; c++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
